// File: rtl/sklansky_wb_frontend.sv
// Wishbone slave front-end for a combinational Sklansky adder.
// Holds operands A/B and carry-in, and launches an add on START.
// After a fixed settle time it captures {cout,sum} into a result FIFO.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   wbs_*                        Wishbone slave (32-bit, byte addressed)
//   add_a_o/add_b_o/add_cin_o    operands driven to the adder
//   add_sum_i/add_cout_i         adder result
//   busy_o                       operation in flight
//   irq_o                        result FIFO non-empty (level)
module sklansky_wb_frontend #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADD_LAT    = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_cin_o,
  input  logic [WIDTH-1:0] add_sum_i,
  input  logic             add_cout_i,
  output logic             busy_o,
  output logic             irq_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned LW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPT} state_e;

  state_e            state_q;
  logic [LW-1:0]     cnt_q;
  logic [WIDTH-1:0]  op_a_q, op_b_q, op_a_d, op_b_d, add_a_q, add_b_q;
  logic              cin_q, cin_d, add_cin_q, err_q, busy_q, irq_q, ack_q;
  logic [31:0]       dat_q, rdata;
  logic [RW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic        hit, acc, wr, rd, start_req, clr, start_ok, start_bad;
  logic        busy_now, empty, full, push, pop;
  logic [2:0]  idx;
  logic [31:0] lane_mask;
  logic        unused_bits;

  // Bus decode
  assign hit       = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign acc       = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr        = acc & wbs_we_i;
  assign rd        = acc & ~wbs_we_i;
  assign idx       = wbs_adr_i[4:2];
  assign start_req = wr & (idx == 3'd2) & wbs_dat_i[0];
  assign clr       = wr & (idx == 3'd2) & wbs_dat_i[2];
  assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  assign busy_now  = (state_q != S_IDLE);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign start_ok  = start_req & ~busy_now & ~full;
  assign start_bad = start_req & (busy_now | full);
  assign pop       = rd & (idx == 3'd4) & ~empty;
  // A clear on the capture edge discards the result
  assign push      = (state_q == S_CAPT) & ~clr & (~full | pop);

  // Operand/CIN register next values with byte-lane merge
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    cin_d  = cin_q;
    if (wr && idx == 3'd0)
      op_a_d = (op_a_q & ~WIDTH'(lane_mask)) | (WIDTH'(wbs_dat_i) & WIDTH'(lane_mask));
    if (wr && idx == 3'd1)
      op_b_d = (op_b_q & ~WIDTH'(lane_mask)) | (WIDTH'(wbs_dat_i) & WIDTH'(lane_mask));
    if (wr && idx == 3'd2)
      cin_d = wbs_dat_i[1];
  end

  // FIFO pointer/count next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata = 32'(op_a_q);
      3'd1: rdata = 32'(op_b_q);
      3'd3: rdata = {24'b0, cin_q, 3'(count_q), err_q, full, empty, busy_now};
      3'd4: rdata = empty ? 32'b0 : 32'(mem_q[rd_ptr_q]);
      default: rdata = '0;
    endcase
  end

  // Register file, FIFO and bus response
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      cin_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cin_q    <= cin_d;
      if (clr)            err_q <= 1'b0;
      else if (start_bad) err_q <= 1'b1;
      if (push) mem_q[wr_ptr_q] <= {add_cout_i, add_sum_i};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= acc;
      dat_q    <= rd ? rdata : 32'b0;
      irq_q    <= (count_d != '0);
    end
  end

  // Operation sequencer: load operands, settle, capture
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q   <= S_RUN;
            cnt_q     <= LW'(ADD_LAT);
            add_a_q   <= op_a_q;
            add_b_q   <= op_b_q;
            add_cin_q <= cin_d;
            busy_q    <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_q == '0) state_q <= S_CAPT;
          else             cnt_q   <= cnt_q - LW'(1);
        end
        S_CAPT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign add_a_o   = add_a_q;
  assign add_b_o   = add_b_q;
  assign add_cin_o = add_cin_q;
  assign busy_o    = busy_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_sklansky_wb_frontend.sv
// Bench for sklansky_wb_frontend: directed scenarios with literal
// expectations plus randomized Wishbone traffic, all outputs compared
// every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_sklansky_wb_frontend;
  localparam int LAT = 1;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_OPA = BASE + 32'h0, A_OPB = BASE + 32'h4,
                          A_CTRL = BASE + 32'h8, A_STAT = BASE + 32'hC,
                          A_RES = BASE + 32'h10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack, busy, irq, add_cin, add_cout;
  logic [31:0] dat_o;
  logic [15:0] add_a, add_b, add_sum;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // The combinational adder being fed
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  sklansky_wb_frontend #(.BASE_ADDR(BASE), .WIDTH(16), .FIFO_DEPTH(4), .ADD_LAT(LAT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
    .add_sum_i(add_sum), .add_cout_i(add_cout),
    .busy_o(busy), .irq_o(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_a, m_b, m_add_a, m_add_b;
  logic        m_cin, m_add_cin, m_err, m_ack, m_busy, m_irq;
  logic [31:0] m_dat;
  int          m_left;          // edges remaining until the result is pushed
  logic [16:0] m_q[$];

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] v;
    v = {16'h0, old};
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic        macc, busy0, full0, pushn;
    logic [31:0] rv;
    logic [16:0] res;
    int          ri;
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_cin = 0; m_err = 0; m_ack = 0; m_dat = 0;
      m_add_a = 0; m_add_b = 0; m_add_cin = 0; m_busy = 0; m_irq = 0;
      m_left = 0; m_q.delete();
    end else begin
      macc  = cyc && stb && ((adr & 32'hFFFF_FFE0) == BASE) && !m_ack;
      ri    = int'(adr[4:2]);
      busy0 = (m_left > 0);
      full0 = (m_q.size() == 4);
      rv    = 0;
      if (macc && !we) begin
        case (ri)
          0: rv = {16'h0, m_a};
          1: rv = {16'h0, m_b};
          3: rv = (32'(m_cin) << 7) | (32'(m_q.size()) << 4) | (32'(m_err) << 3) |
                  (32'(full0) << 2) | (32'(m_q.size() == 0) << 1) | 32'(busy0);
          4: rv = (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0;
          default: rv = 0;
        endcase
      end
      res   = 17'(m_add_a) + 17'(m_add_b) + 17'(m_add_cin);
      pushn = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) pushn = 1'b1;
      end
      if (macc && !we && ri == 4 && m_q.size() > 0) void'(m_q.pop_front());
      if (pushn) m_q.push_back(res);
      if (macc && we) begin
        case (ri)
          0: m_a = merge(m_a, wdat, sel);
          1: m_b = merge(m_b, wdat, sel);
          2: begin
            m_cin = wdat[1];
            if (wdat[0]) begin
              if (busy0 || full0) m_err = 1'b1;
              else begin
                m_left = LAT + 2;
                m_add_a = m_a; m_add_b = m_b; m_add_cin = m_cin;
              end
            end
            if (wdat[2]) begin
              m_q.delete();
              m_err = 1'b0;
            end
          end
          default: ;
        endcase
      end
      m_ack  = macc;
      m_dat  = (macc && !we) ? rv : 32'h0;
      m_busy = (m_left > 0);
      m_irq  = (m_q.size() != 0);
    end
  end

  // Single compare process: every output, every cycle
  always @(negedge clk) begin
    chk("ack", 32'(ack), 32'(m_ack));
    chk("dat_o", dat_o, m_dat);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("add_a", 32'(add_a), 32'(m_add_a));
    chk("add_b", 32'(add_b), 32'(m_add_b));
    chk("add_cin", 32'(add_cin), 32'(m_add_cin));
  end

  // ---------------- bus helpers ----------------
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] r);
    logic got;
    got = 1'b0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; break; end
    end
    r = dat_o;
    cyc = 0; stb = 0; we = 0;
    if (!got) chk("ack_timeout", 32'(got), 32'h1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r;
    wb(1'b1, a, d, s, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    wb(1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic noack(input logic [31:0] a, input logic w);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = $urandom; sel = 4'hF;
    repeat (3) @(negedge clk);
    chk("noack", 32'(ack), 32'h0);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!busy) begin done = 1'b1; break; end
      @(negedge clk);
    end
    if (!done) chk("busy_timeout", 32'(done), 32'h1);
  endtask

  task automatic add_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    wr(A_OPA, {16'h0, a});
    wr(A_OPB, {16'h0, b});
    wr(A_CTRL, {30'h0, c, 1'b1});
    wait_idle();
  endtask

  initial begin
    logic [31:0] r;
    int k;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd(A_STAT, r);                 chk("reset_status", r, 32'h02);

    // Basic add and push latency
    wr(A_OPA, 32'hFFFF); wr(A_OPB, 32'h0001); wr(A_CTRL, 32'h1);
    k = 0;
    while (!irq && k < 20) begin @(negedge clk); k++; end
    chk("push_latency", 32'(k), 32'(LAT + 2));
    chk("busy_after_push", 32'(busy), 32'h0);
    rd(A_RES, r);                  chk("basic_result", r, 32'h0001_0000);
    chk("irq_after_pop", 32'(irq), 32'h0);

    // Carry-in
    add_op(16'h1234, 16'h4321, 1'b1);
    rd(A_STAT, r);                 chk("cin_status", r, 32'h90);
    rd(A_RES, r);                  chk("cin_result", r, 32'h0000_5556);

    // FIFO full, overflow START, in-order drain, empty read
    for (int i = 1; i <= 4; i++) add_op(16'(i), 16'h0, 1'b0);
    wr(A_CTRL, 32'h1);
    rd(A_STAT, r);                 chk("full_status", r, 32'h4C);
    for (int i = 1; i <= 4; i++) begin
      rd(A_RES, r);                chk("drain", r, 32'(i));
    end
    rd(A_RES, r);                  chk("empty_pop", r, 32'h0);
    rd(A_STAT, r);                 chk("err_sticky", r, 32'h0A);
    wr(A_CTRL, 32'h4);

    // Back-to-back START collides
    wr(A_OPA, 32'h5); wr(A_OPB, 32'h7); wr(A_CTRL, 32'h1); wr(A_CTRL, 32'h1);
    wait_idle();
    rd(A_STAT, r);                 chk("collide_status", r, 32'h18);
    rd(A_RES, r);                  chk("collide_result", r, 32'hC);
    wr(A_CTRL, 32'h4);

    // OP_A written mid-run does not disturb in-flight operands
    wr(A_OPA, 32'h10); wr(A_OPB, 32'h20); wr(A_CTRL, 32'h1); wr(A_OPA, 32'hFFFF);
    wait_idle();
    rd(A_RES, r);                  chk("old_a_result", r, 32'h30);
    rd(A_OPA, r);                  chk("new_a_readback", r, 32'hFFFF);

    // Byte lanes and dropped upper bits
    wr(A_OPA, 32'h1100); wr(A_OPA, 32'hAABB, 4'b0001);
    rd(A_OPA, r);                  chk("byte_lane", r, 32'h11BB);
    wr(A_OPB, 32'hDEAD_BEEF);
    rd(A_OPB, r);                  chk("upper_dropped", r, 32'hBEEF);
    rd(BASE + 32'h1C, r);          chk("unmapped_read", r, 32'h0);

    // CLR with two entries pending
    add_op(16'h1, 16'h1, 1'b0); add_op(16'h2, 16'h2, 1'b0);
    rd(A_STAT, r);                 chk("two_pending", r, 32'h20);
    wr(A_CTRL, 32'h4);
    rd(A_STAT, r);                 chk("clr_status", r, 32'h02);
    chk("clr_irq", 32'(irq), 32'h0);

    noack(BASE + 32'h20, 1'b0);
    noack(32'h4000_0000, 1'b1);

    // Async reset mid-RUN
    add_op(16'h7, 16'h8, 1'b0);
    wr(A_OPA, 32'h3); wr(A_CTRL, 32'h1);
    #2 rst_n = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    rd(A_STAT, r);                 chk("rst_status", r, 32'h02);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a, d;
      logic [2:0]  ix;
      ix = 3'($urandom_range(0, 7));
      a  = BASE + {27'h0, ix, 2'($urandom_range(0, 3))};
      d  = $urandom;
      if (ix == 3'd2) d = {29'h0, ($urandom_range(0, 7) == 0), d[1], ($urandom_range(0, 2) != 0)};
      if ($urandom_range(0, 19) == 0) noack(a ^ 32'h0000_0020, 1'($urandom));
      else wb(1'($urandom), a, d, 4'($urandom), r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
